// File: rtl/pipelined_segmented_adder_segment.sv
// adder_segment: SEG_W-bit combinational add of x, y and ci.
// Also reports the carry into its top bit so the final stage can form signed overflow.
module adder_segment #(
    parameter int SEG_W = 4
) (
    input  logic [SEG_W-1:0] x,
    input  logic [SEG_W-1:0] y,
    input  logic             ci,
    output logic [SEG_W-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [SEG_W:0] full;

    always_comb begin
        full     = {1'b0, x} + {1'b0, y} + {{SEG_W{1'b0}}, ci};
        s        = full[SEG_W-1:0];
        co       = full[SEG_W];
        // The carry into the top bit is recovered from its sum bit and its operand bits.
        c_msb_in = full[SEG_W-1] ^ x[SEG_W-1] ^ y[SEG_W-1];
    end

endmodule

// File: rtl/pipelined_segmented_adder.sv
// Pipelined carry-chain adder/subtractor: one SEG_W-bit segment per stage, registered
// carry between stages, valid/ready handshake with a single global advance enable.
module pipelined_segmented_adder #(
    parameter int WIDTH = 16,
    parameter int SEG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG_SAFE = (SEG_W < 1) ? 1 : SEG_W;
    localparam int NSEG     = WIDTH / SEG_SAFE;

    if (SEG_W < 1) begin : g_bad_seg_w
        $error("pipelined_segmented_adder: SEG_W must be at least 1");
    end else if (WIDTH % SEG_SAFE != 0) begin : g_bad_width
        $error("pipelined_segmented_adder: WIDTH must be a multiple of SEG_W");
    end

    logic en;

    always_comb begin
        en       = !out_valid || out_ready;
        in_ready = en;
    end

    for (genvar k = 0; k < NSEG; k++) begin : stage
        localparam int W_IN = WIDTH - k * SEG_W;

        logic [W_IN-1:0]          x_src;
        logic [W_IN-1:0]          y_src;
        logic                     ci_src;
        logic                     v_src;
        logic [SEG_W-1:0]         s;
        logic                     co;
        logic [(k+1)*SEG_W-1:0]   sum_next;
        logic [(k+1)*SEG_W-1:0]   sum_q;
        logic                     v_q;
        logic                     c_q;

        if (k == 0) begin : g_src
            always_comb begin
                x_src    = a;
                y_src    = sub ? ~b : b;
                ci_src   = sub | cin;
                v_src    = in_valid;
                sum_next = s;
            end
        end else begin : g_src
            always_comb begin
                x_src    = stage[k-1].g_ops.a_q;
                y_src    = stage[k-1].g_ops.b_q;
                ci_src   = stage[k-1].c_q;
                v_src    = stage[k-1].v_q;
                sum_next = {s, stage[k-1].sum_q};
            end
        end

        // Operands shrink by one segment per stage; the last stage carries none forward.
        if (k < NSEG - 1) begin : g_ops
            logic [W_IN-SEG_W-1:0] a_q;
            logic [W_IN-SEG_W-1:0] b_q;
            logic                  c_msb_unused;

            adder_segment #(.SEG_W(SEG_W)) u_seg (
                .x        (x_src[SEG_W-1:0]),
                .y        (y_src[SEG_W-1:0]),
                .ci       (ci_src),
                .s        (s),
                .co       (co),
                .c_msb_in (c_msb_unused)
            );

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en && v_src) begin
                    a_q <= x_src[W_IN-1:SEG_W];
                    b_q <= y_src[W_IN-1:SEG_W];
                end
            end
        end else begin : g_last
            logic c_msb;
            logic m_q;

            adder_segment #(.SEG_W(SEG_W)) u_seg (
                .x        (x_src),
                .y        (y_src),
                .ci       (ci_src),
                .s        (s),
                .co       (co),
                .c_msb_in (c_msb)
            );

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    m_q <= 1'b0;
                end else if (en && v_src) begin
                    m_q <= c_msb;
                end
            end
        end

        // Data registers load only behind a valid token, so bubbles leave the output held.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (en) begin
                v_q <= v_src;
                if (v_src) begin
                    c_q   <= co;
                    sum_q <= sum_next;
                end
            end
        end
    end

    always_comb begin
        out_valid = stage[NSEG-1].v_q;
        sum       = stage[NSEG-1].sum_q;
        cout      = stage[NSEG-1].c_q;
        ovf       = stage[NSEG-1].c_q ^ stage[NSEG-1].g_last.m_q;
    end

endmodule

// File: tb/tb_pipelined_segmented_adder.sv
// Self-checking bench for pipelined_segmented_adder (WIDTH=16, SEG_W=4): directed table,
// multi-cycle sequences and random traffic checked against an arithmetic reference model.
module tb_pipelined_segmented_adder;

    localparam int W    = 16;
    localparam int LAT  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;

    int checks   = 0;
    int failures = 0;

    // Expected pipeline occupancy: slot LAT-1 is what the output should show.
    logic         m_v [LAT];
    logic [W-1:0] m_s [LAT];
    logic         m_c [LAT];
    logic         m_o [LAT];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t tv [8];

    pipelined_segmented_adder #(.WIDTH(16), .SEG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
        end
    endtask

    // Arithmetic definition of the result: plain integer add/subtract and range test.
    function automatic void ref_add(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                    input logic rcin, input logic rsub,
                                    output logic [W-1:0] rs, output logic rc, output logic ro);
        int unsigned ua = ra;
        int unsigned ub = rb;
        int          sa = $signed(ra);
        int          sb = $signed(rb);
        int unsigned full;
        int          sres;
        if (rsub) begin
            rc   = (ua >= ub);
            rs   = 16'(ua - ub);
            sres = sa - sb;
        end else begin
            full = ua + ub + (rcin ? 1 : 0);
            rs   = 16'(full);
            rc   = (full > 32'h0000_FFFF);
            sres = sa + sb + (rcin ? 1 : 0);
        end
        ro = (sres > 32767) || (sres < -32768);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < LAT; i++) m_v[i] = 1'b0;
    endtask

    // One clock: drive inputs, check in_ready, clock, advance model, check outputs.
    task automatic step(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tcin, input logic tsub, input logic ordy);
        logic         en_exp;
        logic [W-1:0] rs;
        logic         rc;
        logic         ro;
        in_valid  = v;
        a         = ta;
        b         = tb_;
        cin       = tcin;
        sub       = tsub;
        out_ready = ordy;
        #1;
        en_exp = !m_v[LAT-1] || ordy;
        check("in_ready", {15'b0, in_ready}, {15'b0, en_exp});
        @(posedge clk);
        if (en_exp) begin
            for (int i = LAT - 1; i > 0; i--) begin
                m_v[i] = m_v[i-1];
                m_s[i] = m_s[i-1];
                m_c[i] = m_c[i-1];
                m_o[i] = m_o[i-1];
            end
            ref_add(ta, tb_, tcin, tsub, rs, rc, ro);
            m_v[0] = v;
            m_s[0] = rs;
            m_c[0] = rc;
            m_o[0] = ro;
        end
        #1;
        check("out_valid", {15'b0, out_valid}, {15'b0, m_v[LAT-1]});
        if (m_v[LAT-1]) begin
            check("sum",  sum,               m_s[LAT-1]);
            check("cout", {15'b0, cout},     {15'b0, m_c[LAT-1]});
            check("ovf",  {15'b0, ovf},      {15'b0, m_o[LAT-1]});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic push_rand(input logic ordy);
        step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), ordy);
    endtask

    initial begin
        tv[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tv[1] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tv[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tv[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tv[4] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        tv[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tv[6] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        tv[7] = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};

        model_clear();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst_out_valid", {15'b0, out_valid}, 16'h0);
        check("rst_sum",       sum,                16'h0);
        check("rst_cout",      {15'b0, cout},      16'h0);
        check("rst_ovf",       {15'b0, ovf},       16'h0);
        check("rst_in_ready",  {15'b0, in_ready},  16'h1);
        rst_n = 1'b1;

        // Directed vectors, one at a time: result must appear after exactly LAT edges.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, tv[i].a, tv[i].b, tv[i].cin, tv[i].sub, 1'b1);
            for (int j = 0; j < LAT - 1; j++) begin
                check("tbl_early_valid", {15'b0, out_valid}, 16'h0);
                step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
            end
            check("tbl_valid", {15'b0, out_valid}, 16'h1);
            check("tbl_sum",   sum,                tv[i].sum);
            check("tbl_cout",  {15'b0, cout},      {15'b0, tv[i].cout});
            check("tbl_ovf",   {15'b0, ovf},       {15'b0, tv[i].ovf});
        end
        idle(2);

        // Streaming: 8 back-to-back with cin toggling.
        for (int i = 0; i < 8; i++)
            step(1'b1, 16'($urandom), 16'($urandom), 1'(i), 1'b0, 1'b1);
        idle(LAT + 1);

        // Backpressure: 3 stalled cycles with a valid result, then pop+accept together.
        for (int i = 0; i < LAT; i++) push_rand(1'b1);
        for (int i = 0; i < 3; i++) push_rand(1'b0);
        push_rand(1'b1);
        idle(LAT + 2);

        // Reset with one result out and three in flight.
        for (int i = 0; i < LAT; i++) push_rand(1'b1);
        check("pre_rst_valid", {15'b0, out_valid}, 16'h1);
        out_ready = 1'b0;
        rst_n     = 1'b0;
        model_clear();
        #1;
        check("midrst_out_valid", {15'b0, out_valid}, 16'h0);
        check("midrst_sum",       sum,                16'h0);
        check("midrst_cout",      {15'b0, cout},      16'h0);
        check("midrst_ovf",       {15'b0, ovf},       16'h0);
        check("midrst_in_ready",  {15'b0, in_ready},  16'h1);
        #2;
        rst_n = 1'b1;
        idle(LAT + 2);
        step(1'b1, 16'h00F0, 16'h0F10, 1'b0, 1'b0, 1'b1);
        idle(LAT - 1);
        check("post_rst_valid", {15'b0, out_valid}, 16'h1);
        check("post_rst_sum",   sum,                16'h1000);
        idle(2);

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
        idle(LAT + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
